batch_former: RTL and testbench

//  Downstream stage of the insertion stage: consumes its transaction stream and groups transactions into

---
 rtl/svm_sched_pkg.sv | 16 +
 rtl/dep_conflict_detect.sv | 21 ++
 rtl/batch_former.sv | 144 ++++++++++++++
 tb/tb_batch_former.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/svm_sched_pkg.sv
// Shared scheduler definitions: FSM states, default dependency width, conflict-vector bit positions.
package svm_sched_pkg;

  localparam int DEP_W_DEFAULT = 256;

  localparam int CONF_RAW = 0;
  localparam int CONF_WAW = 1;
  localparam int CONF_WAR = 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/dep_conflict_detect.sv
// Combinational RAW/WAW/WAR check of one transaction's dependency sets against an accumulated batch.
module dep_conflict_detect
  import svm_sched_pkg::*;
#(
  parameter int W = DEP_W_DEFAULT
) (
  input  logic [W-1:0] rd_deps_i,
  input  logic [W-1:0] wr_deps_i,
  input  logic [W-1:0] batch_rd_i,
  input  logic [W-1:0] batch_wr_i,
  output logic [2:0]   conflict_o
);

  always_comb begin
    conflict_o           = '0;
    conflict_o[CONF_RAW] = |(rd_deps_i & batch_wr_i);
    conflict_o[CONF_WAW] = |(wr_deps_i & batch_wr_i);
    conflict_o[CONF_WAR] = |(wr_deps_i & batch_rd_i);
  end

endmodule

// File: rtl/batch_former.sv
// Groups the insertion stream into conflict-free batches, closing on conflict, size cap or idle timeout.
// state   | meaning
// EMPTY   | no batch open; next transaction opens one
// COLLECT | batch open; accepting non-conflicting transactions
// EMIT    | batch closed; waiting for downstream handshake
module batch_former
  import svm_sched_pkg::*;
#(
  parameter int MAX_DEPENDENCIES = DEP_W_DEFAULT,
  parameter int MAX_BATCH_SIZE   = 8,
  parameter int BATCH_TIMEOUT    = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic [63:0]                          s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0]          s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0]          s_axis_tdata_write_dependencies,
  output logic                                 m_batch_valid,
  input  logic                                 m_batch_ready,
  output logic [MAX_BATCH_SIZE*64-1:0]         m_batch_ids,
  output logic [$clog2(MAX_BATCH_SIZE+1)-1:0]  m_batch_size,
  output logic [MAX_DEPENDENCIES-1:0]          m_batch_read_deps,
  output logic [MAX_DEPENDENCIES-1:0]          m_batch_write_deps,
  output logic                                 batch_completed,
  output logic [31:0]                          raw_conflicts,
  output logic [31:0]                          waw_conflicts,
  output logic [31:0]                          war_conflicts,
  output logic [31:0]                          batches_emitted
);

  localparam int SZ_W = $clog2(MAX_BATCH_SIZE + 1);
  localparam int TM_W = (BATCH_TIMEOUT > 1) ? $clog2(BATCH_TIMEOUT) : 1;
  localparam logic [TM_W-1:0] TM_LOAD = TM_W'(BATCH_TIMEOUT - 1);

  state_t                      state_q;
  logic [63:0]                 ids_q [MAX_BATCH_SIZE];
  logic [MAX_DEPENDENCIES-1:0] rd_q, wr_q;
  logic [SZ_W-1:0]             size_q;
  logic [TM_W-1:0]             timer_q;
  logic                        valid_q, done_q;
  logic [31:0]                 raw_q, waw_q, war_q, emit_cnt_q;
  logic [2:0]                  conf_vec;
  logic                        hold, accept;

  dep_conflict_detect #(.W(MAX_DEPENDENCIES)) u_detect (
    .rd_deps_i  (s_axis_tdata_read_dependencies),
    .wr_deps_i  (s_axis_tdata_write_dependencies),
    .batch_rd_i (rd_q),
    .batch_wr_i (wr_q),
    .conflict_o (conf_vec)
  );

  // Gate with tvalid so ready never depends on idle-bus data.
  assign hold          = s_axis_tvalid & (|conf_vec);
  assign s_axis_tready = (state_q == EMPTY) | ((state_q == COLLECT) & ~hold);
  assign accept        = s_axis_tvalid & s_axis_tready;

  // Idle timer counts down from TM_LOAD and closes the batch at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      for (int i = 0; i < MAX_BATCH_SIZE; i++) ids_q[i] <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      size_q     <= '0;
      timer_q    <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      raw_q      <= '0;
      waw_q      <= '0;
      war_q      <= '0;
      emit_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            ids_q[0] <= s_axis_tdata_owner_programID;
            rd_q     <= s_axis_tdata_read_dependencies;
            wr_q     <= s_axis_tdata_write_dependencies;
            size_q   <= SZ_W'(1);
            timer_q  <= TM_LOAD;
            state_q  <= COLLECT;
          end
        end
        COLLECT: begin
          if (hold) begin
            if (conf_vec[CONF_RAW]) raw_q <= raw_q + 32'd1;
            if (conf_vec[CONF_WAW]) waw_q <= waw_q + 32'd1;
            if (conf_vec[CONF_WAR]) war_q <= war_q + 32'd1;
            valid_q <= 1'b1;
            state_q <= EMIT;
          end else if (accept) begin
            for (int i = 0; i < MAX_BATCH_SIZE; i++)
              if (size_q == SZ_W'(i)) ids_q[i] <= s_axis_tdata_owner_programID;
            rd_q    <= rd_q | s_axis_tdata_read_dependencies;
            wr_q    <= wr_q | s_axis_tdata_write_dependencies;
            size_q  <= size_q + SZ_W'(1);
            timer_q <= TM_LOAD;
            if (size_q == SZ_W'(MAX_BATCH_SIZE - 1)) begin
              valid_q <= 1'b1;
              state_q <= EMIT;
            end
          end else if (timer_q == '0) begin
            valid_q <= 1'b1;
            state_q <= EMIT;
          end else begin
            timer_q <= timer_q - TM_W'(1);
          end
        end
        EMIT: begin
          if (m_batch_ready) begin
            for (int i = 0; i < MAX_BATCH_SIZE; i++) ids_q[i] <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            size_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b1;
            emit_cnt_q <= emit_cnt_q + 32'd1;
            state_q    <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_BATCH_SIZE; g++) begin : g_ids
    assign m_batch_ids[64*g +: 64] = ids_q[g];
  end

  assign m_batch_valid      = valid_q;
  assign m_batch_size       = size_q;
  assign m_batch_read_deps  = rd_q;
  assign m_batch_write_deps = wr_q;
  assign batch_completed    = done_q;
  assign raw_conflicts      = raw_q;
  assign waw_conflicts      = waw_q;
  assign war_conflicts      = war_q;
  assign batches_emitted    = emit_cnt_q;

endmodule

// File: tb/tb_batch_former.sv
// Scoreboard bench for batch_former: expected batches queued at stimulus time, checked at handshake.
module tb_batch_former;

  localparam int DW = 256;
  localparam int NB = 8;

  typedef struct packed {
    logic [3:0]      size;
    logic [NB*64-1:0] ids;
    logic [DW-1:0]   rd;
    logic [DW-1:0]   wr;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [63:0]     s_axis_tdata_owner_programID = '0;
  logic [DW-1:0]   s_axis_tdata_read_dependencies = '0;
  logic [DW-1:0]   s_axis_tdata_write_dependencies = '0;
  logic            m_batch_valid;
  logic            m_batch_ready = 1'b0;
  logic [NB*64-1:0] m_batch_ids;
  logic [3:0]      m_batch_size;
  logic [DW-1:0]   m_batch_read_deps, m_batch_write_deps;
  logic            batch_completed;
  logic [31:0]     raw_conflicts, waw_conflicts, war_conflicts, batches_emitted;

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  batch_former #(.MAX_DEPENDENCIES(DW), .MAX_BATCH_SIZE(NB), .BATCH_TIMEOUT(4)) dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .s_axis_tvalid                   (s_axis_tvalid),
    .s_axis_tready                   (s_axis_tready),
    .s_axis_tdata_owner_programID    (s_axis_tdata_owner_programID),
    .s_axis_tdata_read_dependencies  (s_axis_tdata_read_dependencies),
    .s_axis_tdata_write_dependencies (s_axis_tdata_write_dependencies),
    .m_batch_valid                   (m_batch_valid),
    .m_batch_ready                   (m_batch_ready),
    .m_batch_ids                     (m_batch_ids),
    .m_batch_size                    (m_batch_size),
    .m_batch_read_deps               (m_batch_read_deps),
    .m_batch_write_deps              (m_batch_write_deps),
    .batch_completed                 (batch_completed),
    .raw_conflicts                   (raw_conflicts),
    .waw_conflicts                   (waw_conflicts),
    .war_conflicts                   (war_conflicts),
    .batches_emitted                 (batches_emitted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Holds tvalid until accepted; returns on the negedge after the accepting posedge.
  task automatic send(input logic [63:0] id, input logic [DW-1:0] rd, input logic [DW-1:0] wr);
    int n;
    n = 0;
    s_axis_tdata_owner_programID    = id;
    s_axis_tdata_read_dependencies  = rd;
    s_axis_tdata_write_dependencies = wr;
    s_axis_tvalid                   = 1'b1;
    #1;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_accept", 512'(s_axis_tready), 512'(1));
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic cmp_batch(input string tag, input exp_t e);
    chk({tag, "_valid"}, 512'(m_batch_valid), 512'(1));
    chk({tag, "_size"},  512'(m_batch_size), 512'(e.size));
    chk({tag, "_ids"},   m_batch_ids, e.ids);
    chk({tag, "_rd"},    512'(m_batch_read_deps), 512'(e.rd));
    chk({tag, "_wr"},    512'(m_batch_write_deps), 512'(e.wr));
  endtask

  task automatic take_batch(input int hold_cycles);
    exp_t e;
    int   n;
    n = 0;
    while (!m_batch_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("batch_wait", 512'(m_batch_valid), 512'(1));
    chk("sb_nonempty", 512'(sb_q.size() != 0), 512'(1));
    if (m_batch_valid && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      cmp_batch("batch", e);
      chk("emit_tready", 512'(s_axis_tready), 512'(0));
      for (int k = 0; k < hold_cycles; k++) begin
        @(negedge clk);
        cmp_batch("hold", e);
      end
      m_batch_ready = 1'b1;
      @(negedge clk);
      m_batch_ready = 1'b0;
      chk("post_valid", 512'(m_batch_valid), 512'(0));
      chk("post_done", 512'(batch_completed), 512'(1));
      chk("post_size", 512'(m_batch_size), 512'(0));
      @(negedge clk);
      chk("done_pulse", 512'(batch_completed), 512'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   c0, n;

    repeat (3) @(negedge clk);
    chk("rst_tready", 512'(s_axis_tready), 512'(1));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 512'(m_batch_valid), 512'(0));
    chk("rst_tready2", 512'(s_axis_tready), 512'(1));
    chk("rst_done", 512'(batch_completed), 512'(0));
    chk("rst_cnts", {raw_conflicts, waw_conflicts, war_conflicts, batches_emitted}, 512'(0));
    chk("rst_size", 512'(m_batch_size), 512'(0));

    // size cap: eight disjoint writers back-to-back
    e = '0;
    e.size = 4'd8;
    for (int i = 0; i < NB; i++) begin
      e.ids[64*i +: 64] = 64'h100 + 64'(i);
      e.wr[i] = 1'b1;
    end
    sb_q.push_back(e);
    c0 = cyc;
    for (int i = 0; i < NB; i++) send(64'h100 + 64'(i), '0, DW'(1) << i);
    chk("b2b_cycles", 512'(cyc - c0), 512'(8));
    take_batch(0);
    chk("emitted_1", 512'(batches_emitted), 512'(1));

    // RAW: B reads what A wrote
    e = '0; e.size = 4'd1; e.ids[63:0] = 64'hA; e.wr[5] = 1'b1;
    sb_q.push_back(e);
    e = '0; e.size = 4'd1; e.ids[63:0] = 64'hB; e.rd[5] = 1'b1;
    sb_q.push_back(e);
    send(64'hA, '0, DW'(1) << 5);
    fork
      send(64'hB, DW'(1) << 5, '0);
      take_batch(0);
    join
    chk("raw_cnt", 512'(raw_conflicts), 512'(1));
    chk("raw_waw", 512'(waw_conflicts), 512'(0));
    chk("raw_war", 512'(war_conflicts), 512'(0));
    take_batch(0);

    // WAW+WAR together
    e = '0; e.size = 4'd1; e.ids[63:0] = 64'hC0; e.rd[3] = 1'b1; e.wr[4] = 1'b1;
    sb_q.push_back(e);
    e = '0; e.size = 4'd1; e.ids[63:0] = 64'hC1; e.wr[3] = 1'b1; e.wr[4] = 1'b1;
    sb_q.push_back(e);
    send(64'hC0, DW'(1) << 3, DW'(1) << 4);
    fork
      send(64'hC1, '0, (DW'(1) << 3) | (DW'(1) << 4));
      take_batch(0);
    join
    chk("ww_raw", 512'(raw_conflicts), 512'(1));
    chk("ww_waw", 512'(waw_conflicts), 512'(1));
    chk("ww_war", 512'(war_conflicts), 512'(1));
    take_batch(0);
    chk("emitted_5", 512'(batches_emitted), 512'(5));

    // idle timeout, then downstream stalls for 10 cycles
    e = '0; e.size = 4'd1; e.ids[63:0] = 64'hD; e.rd[200] = 1'b1; e.wr[255] = 1'b1;
    sb_q.push_back(e);
    send(64'hD, DW'(1) << 200, DW'(1) << 255);
    n = 0;
    while (!m_batch_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 512'(n), 512'(4));
    take_batch(10);

    // reset while collecting a 3-deep batch
    for (int i = 0; i < 3; i++) send(64'hE0 + 64'(i), '0, DW'(1) << (10 + i));
    chk("pre_rst_size", 512'(m_batch_size), 512'(3));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_size", 512'(m_batch_size), 512'(0));
    chk("mid_rst_cnts", {raw_conflicts, waw_conflicts, war_conflicts, batches_emitted}, 512'(0));
    chk("mid_rst_done", 512'(batch_completed), 512'(0));
    chk("mid_rst_tready", 512'(s_axis_tready), 512'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 512'(batch_completed), 512'(0));
    chk("post_rst_valid", 512'(m_batch_valid), 512'(0));
    e = '0; e.size = 4'd1; e.ids[63:0] = 64'hF; e.wr[12] = 1'b1;
    sb_q.push_back(e);
    send(64'hF, '0, DW'(1) << 12);
    take_batch(0);
    chk("post_rst_emitted", 512'(batches_emitted), 512'(1));
    chk("sb_drained", 512'(sb_q.size()), 512'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
